// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: synchronizes rxd, qualifies start bits on the 16x tick,
// samples mid-bit, assembles the word LSB first and reports parity/framing/break status.
module uart_rx_deserializer #(
  parameter int SYNC_STAGES  = 2,
  parameter int SAMPLE_POINT = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick16,
  input  logic       rxd,
  input  logic [1:0] wls,
  input  logic       pen,
  input  logic       eps,
  input  logic       stick_par,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       framing_err,
  output logic       break_int,
  output logic       rx_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  localparam logic [3:0] SP = 4'(SAMPLE_POINT);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rxd_s;
  logic [3:0]             s_cnt_q, s_cnt_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_bit_q, par_bit_d;
  logic [1:0]             wls_q, wls_d;
  logic                   pen_q, pen_d, eps_q, eps_d, stick_q, stick_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   parity_err_q, parity_err_d;
  logic                   framing_err_q, framing_err_d;
  logic                   break_int_q, break_int_d;
  logic                   mid_bit;
  logic [2:0]             last_bit;
  logic                   exp_par;

  assign sync_d[0] = rxd;
  genvar gi;
  generate
    for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      assign sync_d[gi] = sync_q[gi-1];
    end
  endgenerate
  assign rxd_s = sync_q[SYNC_STAGES-1];

  // Bit centres fall 16 ticks after the qualified start-bit midpoint.
  assign mid_bit  = tick16 && (s_cnt_q == 4'd15);
  assign last_bit = {1'b0, wls_q} + 3'd4;
  assign exp_par  = stick_q ? ~eps_q : (eps_q ? ^shift_q : ~^shift_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      sync_q        <= '1;
      s_cnt_q       <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      par_bit_q     <= 1'b0;
      wls_q         <= '0;
      pen_q         <= 1'b0;
      eps_q         <= 1'b0;
      stick_q       <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
      break_int_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      s_cnt_q       <= s_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      par_bit_q     <= par_bit_d;
      wls_q         <= wls_d;
      pen_q         <= pen_d;
      eps_q         <= eps_d;
      stick_q       <= stick_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      parity_err_q  <= parity_err_d;
      framing_err_q <= framing_err_d;
      break_int_q   <= break_int_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (!rxd_s) state_d = S_START;
      S_START:     if (tick16 && s_cnt_q == SP) state_d = rxd_s ? S_IDLE : S_DATA;
      S_DATA:      if (mid_bit && bit_cnt_q == last_bit) state_d = pen_q ? S_PARITY : S_STOP;
      S_PARITY:    if (mid_bit) state_d = S_STOP;
      S_STOP:      if (mid_bit) state_d = rxd_s ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (rxd_s) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    s_cnt_d   = s_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;
    wls_d     = wls_q;
    pen_d     = pen_q;
    eps_d     = eps_q;
    stick_d   = stick_q;
    if (state_q == S_IDLE) begin
      if (!rxd_s) begin
        s_cnt_d   = '0;
        bit_cnt_d = '0;
        shift_d   = '0;
        par_bit_d = 1'b0;
        wls_d     = wls;
        pen_d     = pen;
        eps_d     = eps;
        stick_d   = stick_par;
      end
    end else if (tick16 && state_q != S_WAIT_HIGH) begin
      s_cnt_d = s_cnt_q + 4'd1;
      if (state_q == S_START && s_cnt_q == SP) begin
        s_cnt_d   = '0;
        bit_cnt_d = '0;
      end
      if (state_q == S_DATA && s_cnt_q == 4'd15) begin
        shift_d[bit_cnt_q] = rxd_s;
        bit_cnt_d          = bit_cnt_q + 3'd1;
      end
      if (state_q == S_PARITY && s_cnt_q == 4'd15) par_bit_d = rxd_s;
    end
  end

  always_comb begin
    rx_valid_d    = (state_q == S_STOP) && mid_bit;
    rx_data_d     = rx_data_q;
    parity_err_d  = parity_err_q;
    framing_err_d = framing_err_q;
    break_int_d   = break_int_q;
    if (rx_valid_d) begin
      rx_data_d     = shift_q;
      parity_err_d  = pen_q && (par_bit_q != exp_par);
      framing_err_d = ~rxd_s;
      break_int_d   = ~rxd_s && (shift_q == 8'h00) && !(pen_q && par_bit_q);
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign parity_err  = parity_err_q;
  assign framing_err = framing_err_q;
  assign break_int   = break_int_q;
  assign rx_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: table-driven frames plus hand sequences for glitch,
// break, framing and mid-frame reset; received words are checked against a scoreboard queue.
module tb_uart_rx_deserializer;

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       bi;
  } exp_t;

  typedef struct {
    logic [1:0] wls;
    logic       pen;
    logic       eps;
    logic       stick;
    logic [7:0] data;
    logic       par_bit;
    logic       stop_bit;
    logic       scramble;
    logic [7:0] exp_data;
    logic       exp_pe;
    logic       exp_fe;
    logic       exp_bi;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick16;
  logic       rxd;
  logic [1:0] wls;
  logic       pen, eps, stick_par;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, framing_err, break_int, rx_busy;

  int   checks = 0;
  int   errors = 0;
  int   valid_cnt = 0;
  exp_t sb_q[$];
  vec_t vecs[11];

  uart_rx_deserializer #(.SYNC_STAGES(2), .SAMPLE_POINT(7)) dut (
    .clk(clk), .rst(rst), .tick16(tick16), .rxd(rxd),
    .wls(wls), .pen(pen), .eps(eps), .stick_par(stick_par),
    .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err),
    .framing_err(framing_err), .break_int(break_int), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  // One tick16 every 4 clocks, changed on the falling edge.
  initial begin
    int tcnt = 0;
    tick16 = 1'b0;
    forever begin
      @(negedge clk);
      tcnt++;
      tick16 = (tcnt % 4 == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst && rx_valid) begin
      exp_t e;
      valid_cnt++;
      $display("RX data=%02h pe=%0b fe=%0b bi=%0b", rx_data, parity_err, framing_err, break_int);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rx_valid got data=%02h want no strobe", rx_data);
      end else begin
        e = sb_q.pop_front();
        check("rx_data", 32'(rx_data), 32'(e.data));
        check("parity_err", 32'(parity_err), 32'(e.pe));
        check("framing_err", 32'(framing_err), 32'(e.fe));
        check("break_int", 32'(break_int), 32'(e.bi));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    idle(64);
  endtask

  task automatic set_cfg(input logic [1:0] w, input logic p, input logic e, input logic s);
    wls = w; pen = p; eps = e; stick_par = s;
  endtask

  task automatic send_frame(input vec_t v);
    int nb;
    nb = int'(v.wls) + 5;
    set_cfg(v.wls, v.pen, v.eps, v.stick);
    send_bit(1'b0);
    if (v.scramble) set_cfg(~v.wls, ~v.pen, ~v.eps, ~v.stick);
    for (int i = 0; i < nb; i++) send_bit(v.data[i]);
    if (v.pen) send_bit(v.par_bit);
    send_bit(v.stop_bit);
    rxd = 1'b1;
    idle(64);
    set_cfg(v.wls, v.pen, v.eps, v.stick);
  endtask

  initial begin
    int v0;
    // wls pen eps stick data par stop scr | exp_data pe fe bi
    vecs[0]  = '{2'd3, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{2'd2, 1'b1, 1'b1, 1'b0, 8'h41, 1'b0, 1'b1, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{2'd2, 1'b1, 1'b1, 1'b0, 8'h41, 1'b1, 1'b1, 1'b0, 8'h41, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{2'd1, 1'b1, 1'b0, 1'b0, 8'h2D, 1'b1, 1'b1, 1'b0, 8'h2D, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{2'd1, 1'b1, 1'b0, 1'b0, 8'h2D, 1'b0, 1'b1, 1'b0, 8'h2D, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{2'd3, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{2'd3, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{2'd0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h1F, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{2'd0, 1'b0, 1'b0, 1'b0, 8'h0A, 1'b0, 1'b1, 1'b1, 8'h0A, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{2'd3, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{2'd2, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};

    rst = 1'b0;
    rxd = 1'b1;
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
    idle(5);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    check("reset_flags", 32'({parity_err, framing_err, break_int}), 32'd0);
    check("reset_rx_busy", 32'(rx_busy), 32'd0);
    rst = 1'b1;
    idle(20);

    for (int i = 0; i < 11; i++) begin
      sb_q.push_back('{vecs[i].exp_data, vecs[i].exp_pe, vecs[i].exp_fe, vecs[i].exp_bi});
      send_frame(vecs[i]);
      check($sformatf("vec%0d_idle_after", i), 32'(rx_busy), 32'd0);
    end

    // Short low glitch must be rejected at the start-bit sample point.
    v0 = valid_cnt;
    rxd = 1'b0;
    idle(10);
    check("glitch_busy_high", 32'(rx_busy), 32'd1);
    idle(10);
    rxd = 1'b1;
    idle(60);
    check("glitch_busy_low", 32'(rx_busy), 32'd0);
    check("glitch_no_valid", 32'(valid_cnt - v0), 32'd0);

    // Line held low for 15 bit times with 8E1: one break word only.
    set_cfg(2'd3, 1'b1, 1'b1, 1'b0);
    v0 = valid_cnt;
    sb_q.push_back('{8'h00, 1'b0, 1'b1, 1'b1});
    rxd = 1'b0;
    idle(15 * 64);
    check("break_busy_while_low", 32'(rx_busy), 32'd1);
    rxd = 1'b1;
    idle(128);
    check("break_one_valid", 32'(valid_cnt - v0), 32'd1);
    check("break_idle_after", 32'(rx_busy), 32'd0);

    // 8N1 0x3C with stop bit low: framing error, then WAIT_HIGH until the line rises.
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
    v0 = valid_cnt;
    sb_q.push_back('{8'h3C, 1'b0, 1'b1, 1'b0});
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'((8'h3C >> i) & 8'h01));
    send_bit(1'b0);
    idle(200);
    check("frame_err_valid", 32'(valid_cnt - v0), 32'd1);
    check("frame_err_wait_high", 32'(rx_busy), 32'd1);
    rxd = 1'b1;
    idle(8);
    check("frame_err_release", 32'(rx_busy), 32'd0);
    idle(64);

    // Reset during bit 4 drops the partial word and clears all outputs.
    v0 = valid_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rxd = 1'b0;
    idle(20);
    rst = 1'b0;
    idle(3);
    check("midrst_rx_valid", 32'(rx_valid), 32'd0);
    check("midrst_rx_data", 32'(rx_data), 32'd0);
    check("midrst_flags", 32'({parity_err, framing_err, break_int}), 32'd0);
    check("midrst_rx_busy", 32'(rx_busy), 32'd0);
    rxd = 1'b1;
    idle(3);
    rst = 1'b1;
    idle(200);
    check("midrst_no_valid", 32'(valid_cnt - v0), 32'd0);
    begin
      vec_t v;
      v = '{2'd0, 1'b0, 1'b0, 1'b0, 8'h15, 1'b0, 1'b1, 1'b0, 8'h15, 1'b0, 1'b0, 1'b0};
      sb_q.push_back('{v.exp_data, v.exp_pe, v.exp_fe, v.exp_bi});
      send_frame(v);
    end
    check("post_reset_valid", 32'(valid_cnt - v0), 32'd1);

    idle(20);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
